// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter stage: state encoding and default datapath width.
// Imported by the interface, the quantum counter and the top.
package pc_pkg;

  localparam int LARGURA_PADRAO = 32;

  typedef enum logic [1:0] {
    EXECUTA   = 2'd0,
    ESPERA_IN = 2'd1,
    PARADO    = 2'd2
  } estado_t;

endpackage

// File: rtl/unidade_pc_quantum_if.sv
// Control-unit/PC-stage bundle: decoded instruction controls in, PC and commit status out.
// The master side is the control unit (or a bench standing in for it).
interface unidade_pc_quantum_if
  import pc_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
);

  logic               jump;
  logic [LARGURA-1:0] jumpE;
  logic               halt;
  logic               escreverIn;
  logic               confirmaIn;
  logic               continuar;
  logic               escreverQuantum;
  logic [LARGURA-1:0] quantum;
  logic [LARGURA-1:0] pc;
  logic [LARGURA-1:0] pcSalvo;
  logic               habilitaEscrita;
  logic               preempcao;
  logic               parado;

  modport master (
    output jump, jumpE, halt, escreverIn, confirmaIn, continuar, escreverQuantum, quantum,
    input  pc, pcSalvo, habilitaEscrita, preempcao, parado
  );

  modport slave (
    input  jump, jumpE, halt, escreverIn, confirmaIn, continuar, escreverQuantum, quantum,
    output pc, pcSalvo, habilitaEscrita, preempcao, parado
  );

endinterface

// File: rtl/unidade_pc_quantum_contador.sv
// Preemption quantum counter: loads on QTM, counts committed instructions down, flags expiry.
// A value of zero means preemption is disabled.
module contador_quantum
  import pc_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               commit,
  input  logic               escreverQuantum,
  input  logic [LARGURA-1:0] quantum,
  output logic               expira
);

  localparam logic [LARGURA-1:0] UM = LARGURA'(1);

  logic [LARGURA-1:0] contQ;

  // A load wins over the decrement, so the QTM instruction itself can never trigger expiry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contQ <= '0;
    end else if (commit) begin
      if (escreverQuantum) begin
        contQ <= quantum;
      end else if (contQ != '0) begin
        contQ <= contQ - UM;
      end
    end
  end

  assign expira = commit && (contQ == UM) && !escreverQuantum;

endmodule

// File: rtl/unidade_pc_quantum.sv
// Program-counter stage: holds PC, stalls on HLT and IN, and redirects to the OS vector when
// the quantum expires. habilitaEscrita is the commit strobe that gates RF/memory writes.
module unidade_pc_quantum
  import pc_pkg::*;
#(
  parameter int                 LARGURA    = LARGURA_PADRAO,
  parameter logic [LARGURA-1:0] PC_INICIAL = '0,
  parameter logic [LARGURA-1:0] VETOR_SO   = '0
) (
  input logic                  clock,
  input logic                  reset,
  unidade_pc_quantum_if.slave  bus
);

  localparam logic [LARGURA-1:0] UM = LARGURA'(1);

  estado_t            estado;
  estado_t            estadoProx;
  logic               commit;
  logic               expira;
  logic [LARGURA-1:0] alvo;
  logic [LARGURA-1:0] pcReg;
  logic [LARGURA-1:0] pcSalvoReg;
  logic               preempcaoReg;
  logic               paradoReg;

  contador_quantum #(
    .LARGURA(LARGURA)
  ) u_contador (
    .clock          (clock),
    .reset          (reset),
    .commit         (commit),
    .escreverQuantum(bus.escreverQuantum),
    .quantum        (bus.quantum),
    .expira         (expira)
  );

  // Commit happens in the cycle the instruction completes: immediately in EXECUTA,
  // or in the confirmaIn cycle for an IN; HLT never commits.
  always_comb begin
    estadoProx = estado;
    commit     = 1'b0;
    unique case (estado)
      EXECUTA: begin
        if (bus.halt) begin
          estadoProx = PARADO;
        end else if (bus.escreverIn) begin
          estadoProx = ESPERA_IN;
        end else begin
          commit = 1'b1;
        end
      end
      ESPERA_IN: begin
        if (bus.confirmaIn) begin
          commit     = 1'b1;
          estadoProx = EXECUTA;
        end
      end
      PARADO: begin
        if (bus.continuar) begin
          estadoProx = EXECUTA;
        end
      end
      default: estadoProx = EXECUTA;
    endcase
  end

  assign alvo = bus.jump ? bus.jumpE : pcReg + UM;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= EXECUTA;
      paradoReg <= 1'b0;
    end else begin
      estado    <= estadoProx;
      paradoReg <= (estadoProx == PARADO);
    end
  end

  // On expiry the would-be next PC becomes the return address and fetch goes to the OS.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pcReg        <= PC_INICIAL;
      pcSalvoReg   <= '0;
      preempcaoReg <= 1'b0;
    end else begin
      preempcaoReg <= 1'b0;
      if (commit) begin
        if (expira) begin
          pcReg        <= VETOR_SO;
          pcSalvoReg   <= alvo;
          preempcaoReg <= 1'b1;
        end else begin
          pcReg <= alvo;
        end
      end else if (estado == PARADO && bus.continuar) begin
        pcReg <= pcReg + UM;
      end
    end
  end

  assign bus.pc              = pcReg;
  assign bus.pcSalvo         = pcSalvoReg;
  assign bus.habilitaEscrita = commit;
  assign bus.preempcao       = preempcaoReg;
  assign bus.parado          = paradoReg;

endmodule

// File: tb/tb_unidade_pc_quantum.sv
// Directed bench for the PC stage: sequencing, jumps/wrap, IN and HLT stalls, quantum expiry,
// QTM reload, disabled quantum and reset during a stall. Expected values are hand-computed.
module tb_unidade_pc_quantum;

  logic clock;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  unidade_pc_quantum_if #(.LARGURA(32)) bus ();

  unidade_pc_quantum #(
    .LARGURA   (32),
    .PC_INICIAL(32'd0),
    .VETOR_SO  (32'd100)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic j, input logic [31:0] je, input logic h,
                               input logic ei, input logic ci, input logic co,
                               input logic eq, input logic [31:0] q);
    bus.jump            = j;
    bus.jumpE           = je;
    bus.halt            = h;
    bus.escreverIn      = ei;
    bus.confirmaIn      = ci;
    bus.continuar       = co;
    bus.escreverQuantum = eq;
    bus.quantum         = q;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic pulseReset();
    @(posedge clock);
    #1;
    idle();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic jumpTo(input logic [31:0] dest);
    applyStimulus(1'b1, dest, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    idle();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    #3;
    checks++; if (bus.pc !== 32'd0) begin failures++; $display("[TB] FAIL reset_pc got=%0d exp=0", bus.pc); end
    checks++; if (bus.pcSalvo !== 32'd0) begin failures++; $display("[TB] FAIL reset_pcSalvo got=%0d exp=0", bus.pcSalvo); end
    checks++; if (bus.preempcao !== 1'b0) begin failures++; $display("[TB] FAIL reset_preempcao got=%b exp=0", bus.preempcao); end
    checks++; if (bus.parado !== 1'b0) begin failures++; $display("[TB] FAIL reset_parado got=%b exp=0", bus.parado); end
    #8;
    reset = 1'b1;
  endtask

  task automatic test_sequencia();
    checks++; if (bus.habilitaEscrita !== 1'b1) begin failures++; $display("[TB] FAIL seq_hab0 got=%b exp=1", bus.habilitaEscrita); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (bus.pc !== 32'(i)) begin failures++; $display("[TB] FAIL seq_pc got=%0d exp=%0d", bus.pc, i); end
      checks++; if (bus.habilitaEscrita !== 1'b1) begin failures++; $display("[TB] FAIL seq_hab got=%b exp=1", bus.habilitaEscrita); end
    end
  endtask

  task automatic test_jump();
    jumpTo(32'd5);
    checks++; if (bus.pc !== 32'd5) begin failures++; $display("[TB] FAIL jump_to5 got=%0d exp=5", bus.pc); end
    jumpTo(32'd40);
    checks++; if (bus.pc !== 32'd40) begin failures++; $display("[TB] FAIL jump_to40 got=%0d exp=40", bus.pc); end
    jumpTo(32'hFFFF_FFFF);
    checks++; if (bus.pc !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL jump_allones got=%h exp=ffffffff", bus.pc); end
    tick();
    checks++; if (bus.pc !== 32'd0) begin failures++; $display("[TB] FAIL wrap_pc got=%h exp=0", bus.pc); end
  endtask

  task automatic test_in();
    jumpTo(32'd7);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    checks++; if (bus.habilitaEscrita !== 1'b0) begin failures++; $display("[TB] FAIL in_hab_issue got=%b exp=0", bus.habilitaEscrita); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (bus.pc !== 32'd7) begin failures++; $display("[TB] FAIL in_hold_pc got=%0d exp=7", bus.pc); end
      checks++; if (bus.habilitaEscrita !== 1'b0) begin failures++; $display("[TB] FAIL in_hold_hab got=%b exp=0", bus.habilitaEscrita); end
    end
    bus.confirmaIn = 1'b1;
    #1;
    checks++; if (bus.habilitaEscrita !== 1'b1) begin failures++; $display("[TB] FAIL in_confirm_hab got=%b exp=1", bus.habilitaEscrita); end
    tick();
    idle();
    checks++; if (bus.pc !== 32'd8) begin failures++; $display("[TB] FAIL in_after_pc got=%0d exp=8", bus.pc); end
  endtask

  task automatic test_halt();
    jumpTo(32'd9);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    checks++; if (bus.habilitaEscrita !== 1'b0) begin failures++; $display("[TB] FAIL hlt_hab_issue got=%b exp=0", bus.habilitaEscrita); end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (bus.parado !== 1'b1) begin failures++; $display("[TB] FAIL hlt_parado got=%b exp=1", bus.parado); end
      checks++; if (bus.pc !== 32'd9) begin failures++; $display("[TB] FAIL hlt_pc got=%0d exp=9", bus.pc); end
      checks++; if (bus.habilitaEscrita !== 1'b0) begin failures++; $display("[TB] FAIL hlt_hab got=%b exp=0", bus.habilitaEscrita); end
    end
    bus.continuar = 1'b1;
    tick();
    idle();
    checks++; if (bus.pc !== 32'd10) begin failures++; $display("[TB] FAIL hlt_resume_pc got=%0d exp=10", bus.pc); end
    checks++; if (bus.parado !== 1'b0) begin failures++; $display("[TB] FAIL hlt_resume_parado got=%b exp=0", bus.parado); end
  endtask

  task automatic test_quantum();
    pulseReset();
    jumpTo(32'd2);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd3);
    tick();
    idle();
    checks++; if (bus.pc !== 32'd3) begin failures++; $display("[TB] FAIL qtm_pc3 got=%0d exp=3", bus.pc); end
    tick();
    tick();
    checks++; if (bus.pc !== 32'd5) begin failures++; $display("[TB] FAIL qtm_pc5 got=%0d exp=5", bus.pc); end
    checks++; if (bus.preempcao !== 1'b0) begin failures++; $display("[TB] FAIL qtm_early_pre got=%b exp=0", bus.preempcao); end
    tick();
    checks++; if (bus.pc !== 32'd100) begin failures++; $display("[TB] FAIL qtm_vector got=%0d exp=100", bus.pc); end
    checks++; if (bus.pcSalvo !== 32'd6) begin failures++; $display("[TB] FAIL qtm_pcSalvo got=%0d exp=6", bus.pcSalvo); end
    checks++; if (bus.preempcao !== 1'b1) begin failures++; $display("[TB] FAIL qtm_pulse got=%b exp=1", bus.preempcao); end
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++; if (bus.preempcao !== 1'b0) begin failures++; $display("[TB] FAIL qtm_after_pre got=%b exp=0", bus.preempcao); end
      checks++; if (bus.pc !== 32'(100 + i)) begin failures++; $display("[TB] FAIL qtm_after_pc got=%0d exp=%0d", bus.pc, 100 + i); end
    end
  endtask

  task automatic test_recarga();
    pulseReset();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd2);
    tick();
    idle();
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd5);
    tick();
    idle();
    checks++; if (bus.pc !== 32'd3) begin failures++; $display("[TB] FAIL rec_pc got=%0d exp=3", bus.pc); end
    checks++; if (bus.preempcao !== 1'b0) begin failures++; $display("[TB] FAIL rec_no_pre got=%b exp=0", bus.preempcao); end
    bus.escreverIn = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bus.confirmaIn = 1'b1;
    tick();
    idle();
    checks++; if (bus.pc !== 32'd4) begin failures++; $display("[TB] FAIL rec_in_pc got=%0d exp=4", bus.pc); end
    for (int i = 5; i <= 7; i++) begin
      tick();
      checks++; if (bus.preempcao !== 1'b0 || bus.pc !== 32'(i)) begin failures++; $display("[TB] FAIL rec_count pc=%0d pre=%b exp_pc=%0d exp_pre=0", bus.pc, bus.preempcao, i); end
    end
    jumpTo(32'd50);
    checks++; if (bus.pc !== 32'd100) begin failures++; $display("[TB] FAIL rec_vector got=%0d exp=100", bus.pc); end
    checks++; if (bus.pcSalvo !== 32'd50) begin failures++; $display("[TB] FAIL rec_pcSalvo got=%0d exp=50", bus.pcSalvo); end
    checks++; if (bus.preempcao !== 1'b1) begin failures++; $display("[TB] FAIL rec_pulse got=%b exp=1", bus.preempcao); end
  endtask

  task automatic test_quantum_zero();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd3);
    tick();
    bus.quantum = 32'd0;
    tick();
    idle();
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (bus.preempcao !== 1'b0) begin failures++; $display("[TB] FAIL q0_pre got=%b exp=0", bus.preempcao); end
    end
    checks++; if (bus.pc !== 32'd110) begin failures++; $display("[TB] FAIL q0_pc got=%0d exp=110", bus.pc); end
  endtask

  task automatic test_reset_espera();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    checks++; if (bus.habilitaEscrita !== 1'b0) begin failures++; $display("[TB] FAIL rst_wait_hab got=%b exp=0", bus.habilitaEscrita); end
    reset = 1'b0;
    #1;
    checks++; if (bus.pc !== 32'd0) begin failures++; $display("[TB] FAIL rst_wait_pc got=%0d exp=0", bus.pc); end
    checks++; if (bus.pcSalvo !== 32'd0) begin failures++; $display("[TB] FAIL rst_wait_pcSalvo got=%0d exp=0", bus.pcSalvo); end
    idle();
    #1;
    reset = 1'b1;
    #1;
    checks++; if (bus.habilitaEscrita !== 1'b1) begin failures++; $display("[TB] FAIL rst_wait_exec got=%b exp=1", bus.habilitaEscrita); end
    tick();
    checks++; if (bus.pc !== 32'd1) begin failures++; $display("[TB] FAIL rst_wait_next got=%0d exp=1", bus.pc); end
  endtask

  initial begin
    test_reset();
    test_sequencia();
    test_jump();
    test_in();
    test_halt();
    test_quantum();
    test_recarga();
    test_quantum_zero();
    test_reset_espera();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
